// File: rtl/store_align_buffer_if.sv
// Store-path bundle: EX/MEM store request, memory write port and buffer status.
// The slave modport is the store buffer; master is the pipeline/memory environment.
interface store_align_buffer_if #(
    parameter int WIDTH = 32
);
    logic             st_valid_EXMEM;
    logic [WIDTH-1:0] st_addr_EXMEM;
    logic [WIDTH-1:0] st_data_EXMEM;
    logic [2:0]       funct3_EXMEM;
    logic             st_ready_MEMEX;
    logic             mem_wr_en;
    logic [WIDTH-1:0] mem_wr_addr;
    logic [WIDTH-1:0] mem_wr_data;
    logic [3:0]       mem_wr_be;
    logic             mem_wr_ready;
    logic             sb_empty;
    logic             misaligned_store;

    modport slave (
        input  st_valid_EXMEM, st_addr_EXMEM, st_data_EXMEM, funct3_EXMEM, mem_wr_ready,
        output st_ready_MEMEX, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be,
               sb_empty, misaligned_store
    );

    modport master (
        output st_valid_EXMEM, st_addr_EXMEM, st_data_EXMEM, funct3_EXMEM, mem_wr_ready,
        input  st_ready_MEMEX, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be,
               sb_empty, misaligned_store
    );
endinterface

// File: rtl/store_align_buffer.sv
// MEM-stage store aligner + FIFO store buffer draining to data memory.
// STORE_MISALIGN_SPLIT_EN: split word-spanning stores into two beats instead of rejecting them.
module store_align_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    store_align_buffer_if.slave   sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;

    logic [WIDTH-1:0] addr_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [3:0]       be_mem   [DEPTH];

    logic [1:0]       off;
    logic [WIDTH-1:0] word_addr;
    logic [WIDTH-1:0] rot_data;
    logic [3:0]       base_mask;
    logic             f3_valid;
    logic [7:0]       shifted;
    logic             spanning;
    logic             not_full;
    logic             accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_addr;
    logic [WIDTH-1:0] push_data;
    logic [3:0]       push_be;

    assign off       = sb.st_addr_EXMEM[1:0];
    assign word_addr = {sb.st_addr_EXMEM[WIDTH-1:2], 2'b00};

    always_comb begin
        rot_data = sb.st_data_EXMEM;
        case (off)
            2'd1: rot_data = {sb.st_data_EXMEM[23:0], sb.st_data_EXMEM[31:24]};
            2'd2: rot_data = {sb.st_data_EXMEM[15:0], sb.st_data_EXMEM[31:16]};
            2'd3: rot_data = {sb.st_data_EXMEM[7:0],  sb.st_data_EXMEM[31:8]};
            default: rot_data = sb.st_data_EXMEM;
        endcase
    end

    always_comb begin
        base_mask = 4'b0000;
        f3_valid  = 1'b1;
        case (sb.funct3_EXMEM)
            3'b000:  base_mask = 4'b0001;
            3'b001:  base_mask = 4'b0011;
            3'b010:  base_mask = 4'b1111;
            default: f3_valid  = 1'b0;
        endcase
    end

    // Upper nibble of the shifted mask marks lanes that fall into the next word.
    assign shifted  = {4'b0000, base_mask} << off;
    assign spanning = |shifted[7:4];
    assign not_full = count_reg < DEPTH_CNT;
    assign accept   = sb.st_valid_EXMEM && sb.st_ready_MEMEX;
    assign pop      = sb.mem_wr_en && sb.mem_wr_ready;

`ifdef STORE_MISALIGN_SPLIT_EN
    typedef enum logic {IDLE, SPLIT2} state_t;
    state_t           state_reg;
    logic [WIDTH-1:0] b2_addr_reg;
    logic [WIDTH-1:0] b2_data_reg;
    logic [3:0]       b2_be_reg;

    assign sb.st_ready_MEMEX   = not_full && (state_reg == IDLE);
    assign sb.misaligned_store = 1'b0;
    assign push      = (state_reg == SPLIT2) ? not_full : (accept && f3_valid);
    assign push_addr = (state_reg == SPLIT2) ? b2_addr_reg : word_addr;
    assign push_data = (state_reg == SPLIT2) ? b2_data_reg : rot_data;
    assign push_be   = (state_reg == SPLIT2) ? b2_be_reg   : shifted[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && f3_valid && spanning) begin
                        state_reg   <= SPLIT2;
                        b2_addr_reg <= word_addr + WIDTH'(4);
                        b2_data_reg <= rot_data;
                        b2_be_reg   <= shifted[7:4];
                    end
                end
                SPLIT2: begin
                    if (not_full) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
`else
    logic is_sh;
    logic nat_misaligned;
    logic misaligned_reg;

    // Every misaligned SW and SH at offset 3 spans; SH at offset 1 is the only in-word case.
    assign is_sh          = (sb.funct3_EXMEM == 3'b001);
    assign nat_misaligned = spanning || (is_sh && off[0]);

    assign sb.st_ready_MEMEX   = not_full;
    assign sb.misaligned_store = misaligned_reg;
    assign push      = accept && f3_valid && !nat_misaligned;
    assign push_addr = word_addr;
    assign push_data = rot_data;
    assign push_be   = shifted[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_reg <= 1'b0;
        end else begin
            misaligned_reg <= accept && f3_valid && nat_misaligned;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_reg == PTR_W'(gi))) begin
                    addr_mem[gi] <= push_addr;
                    data_mem[gi] <= push_data;
                    be_mem[gi]   <= push_be;
                end
            end
        end
    endgenerate

    assign sb.mem_wr_en   = (count_reg != '0);
    assign sb.sb_empty    = (count_reg == '0);
    assign sb.mem_wr_addr = addr_mem[head_reg];
    assign sb.mem_wr_data = data_mem[head_reg];
    assign sb.mem_wr_be   = be_mem[head_reg];
endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- MEM-stage store path: the write-direction counterpart of load extraction in write-back.
- Takes SB/SH/SW requests from EX/MEM and aligns rs2 data into byte lanes.
- Generates 4-bit byte enables and queues entries in a small FIFO store buffer.
- Drains the buffer to data memory over a valid/ready write port, decoupling pipeline stores from memory backpressure.

Parameters:
- WIDTH, 32, data/address width (fixed 32 for RV32).
- DEPTH, 4, store buffer entries (power of two, >= 2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- st_valid_EXMEM  input  1  store request valid
- st_addr_EXMEM  input  WIDTH  byte address (ALU result)
- st_data_EXMEM  input  WIDTH  rs2 store data, unaligned (low bits meaningful)
- funct3_EXMEM  input  3  000=SB, 001=SH, 010=SW; others invalid
- st_ready_MEMEX  output  1  buffer can accept a request this cycle
- mem_wr_en  output  1  head entry valid toward memory
- mem_wr_addr  output  WIDTH  word-aligned address (bits [1:0]=00)
- mem_wr_data  output  WIDTH  lane-aligned data
- mem_wr_be  output  4  byte enables, bit i = byte lane i
- mem_wr_ready  input  1  memory accepts head this cycle
- sb_empty  output  1  buffer holds no entries (fence/drain indication)
- misaligned_store  output  1  one-cycle pulse: misaligned store rejected

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - count, head and tail pointers, FSM state go to 0 / IDLE.
  - Next cycle: mem_wr_en=0, sb_empty=1, misaligned_store=0, st_ready_MEMEX=1.
  - A request presented in the reset cycle is discarded.
  - Reset mid-drain drops all entries, including an in-flight split second beat.
- Handshake:
  - A request is accepted when st_valid_EXMEM && st_ready_MEMEX.
  - st_ready_MEMEX = (count < DEPTH) && state==IDLE. It is not a function of mem_wr_ready (no full-buffer pass-through).
- Alignment (off = st_addr[1:0]):
  - Rotated data = st_data rotated left by 8*off.
  - Base mask: SB=0001, SH=0011, SW=1111.
  - shifted = base mask << off (8-bit).
  - Beat 1: be = shifted[3:0], addr = {st_addr[31:2],2'b00}, data = rotated data.
- Misalignment:
  - Naturally misaligned: SH with off odd, or SW with off != 0.
  - Handled per Optional Feature.
- Invalid funct3: request is accepted (consumes handshake), nothing is enqueued, no flag.
- Drain:
  - mem_wr_en = !empty; addr/data/be driven combinationally from the head entry.
  - Pop on mem_wr_en && mem_wr_ready.
  - Minimum latency is 1 cycle: a store accepted at edge N appears on mem_wr_en after edge N.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap mod DEPTH.
- Full: st_ready_MEMEX=0. A pop in that cycle does not enable a same-cycle push; st_ready rises the following cycle.
- Ordering: strict FIFO. The second beat of a split store directly follows its first beat.
- sb_empty = (count == 0).

Optional Feature:
- Macro: STORE_MISALIGN_SPLIT_EN.
- Defined: two-state FSM, IDLE and SPLIT2.
  - Accept a store where shifted[7:4] != 0 (spanning a word boundary): enqueue beat 1 and register beat 2, then go to SPLIT2.
  - Beat 2: addr = beat-1 addr + 4 (wraps mod 2^32), be = shifted[7:4], same rotated data.
  - In SPLIT2: st_ready_MEMEX=0. Push beat 2 when count < DEPTH, then return to IDLE.
  - Non-spanning odd SH (off=1, be=0110) is a single beat.
  - misaligned_store is tied 0.
- Undefined:
  - No SPLIT2 state.
  - Any naturally misaligned store is accepted but not enqueued.
  - misaligned_store pulses 1 for exactly one cycle, in the cycle after acceptance (registered).

Test Plan:
- Reset, then SB addr=0x1003 data=0x000000A5 -> next cycle mem_wr_en=1, addr=0x1000, data=0xA5xxxxxx (lane3=A5), be=1000; sb_empty=0.
- SH addr=0x2002 data=0x1234BEEF, mem_wr_ready=1 -> addr=0x2000, be=1100, data[31:16]=0xBEEF; entry pops that cycle; sb_empty=1 next cycle.
- mem_wr_ready=0, four SW to 0x0,0x4,0x8,0xC -> st_ready_MEMEX=0 after the fourth. Raise ready -> writes drain in order 0x0..0xC, one per cycle; st_ready returns 1 the cycle after the first pop.
- Full buffer with pop and st_valid in the same cycle -> no push; count goes DEPTH-1; request accepted next cycle.
- SW addr=0x3001 data=0xAABBCCDD:
  - Split defined -> beats (0x3000, be=1110, data=0xBBCCDDAA) then (0x3004, be=0001, same data); st_ready=0 for one cycle.
  - Split undefined -> nothing enqueued; misaligned_store=1 for exactly one cycle.
- Assert reset while 3 entries queued and mem_wr_ready=0 -> next cycle mem_wr_en=0, sb_empty=1, st_ready_MEMEX=1; no stale entry ever emitted.
